stdcore_rfifo_lvl: RTL and testbench
====================================

STDCORE_RFIFO_LVL -- requirements
Module: stdcore_rfifo_lvl

Interface
REQ-001 The block SHALL have parameter DW, default 1: data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4: total entries, output register included; legal range DEPTH >= 2.
REQ-003 The block SHALL have parameter AF_LVL, default DEPTH-1: almost-full threshold; legal range 1..DEPTH.
REQ-004 The block SHALL have parameter AE_LVL, default 1: almost-empty threshold; legal range 0..DEPTH-1.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous content clear.
REQ-008 The block SHALL have ports p (input, DW bits), p_val (input, 1 bit) and p_rdy (output, 1 bit): producer val/rdy side.
REQ-009 The block SHALL have ports c (output, DW bits), c_val (output, 1 bit) and c_rdy (input, 1 bit): consumer val/rdy side.
REQ-010 The block SHALL have port count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-011 The block SHALL have ports afull and aempty, outputs, 1 bit each: level flags.

Function
REQ-012 push = p_val & p_rdy and pop = c_val & c_rdy SHALL be the only transfer events.
REQ-013 Data SHALL leave in strict FIFO order, with no loss or duplication.
REQ-014 c and c_val SHALL be driven directly from flops, with no combinational path from p, p_val or c_rdy.
REQ-015 p_rdy SHALL be (count < DEPTH) & ~flush, decoded from state only, with no combinational path from c_rdy.
REQ-016 A push into an empty FIFO at edge t SHALL give c_val=1 and c=p immediately after edge t (latency 1 cycle).
REQ-017 While c_val=1 and no pop occurs, c and c_val SHALL hold stable.
REQ-018 When c_val=0, c SHALL retain the last value presented.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged; at count=1 the pushed word SHALL load the output register and c_val SHALL stay 1.
REQ-020 count SHALL increment by 1 on push-only, decrement by 1 on pop-only, and otherwise hold.
REQ-021 count SHALL never exceed DEPTH and never underflow.
REQ-022 Internal storage SHALL be a (DEPTH-1)-entry circular buffer; read and write pointers SHALL wrap from DEPTH-2 to 0.
REQ-023 Back-to-back push and pop SHALL sustain 1 word per cycle at any count below DEPTH.
REQ-024 At count=DEPTH, p_rdy=0 for that cycle even if a pop occurs.
REQ-025 afull SHALL equal (count >= AF_LVL) and aempty SHALL equal (count <= AE_LVL), both decoded from the count register.
REQ-026 flush=1 at an edge SHALL give count=0, c_val=0 and both pointers=0 after that edge, with c unchanged.
REQ-027 A pop completing in a flush cycle SHALL be legal, and its data SHALL be considered consumed.
REQ-028 Parameter violations (DEPTH<2, AF_LVL or AE_LVL out of range) SHALL report a message and $stop at simulation start.

Reset
REQ-029 rst_n=0 at an edge SHALL give count=0, c_val=0, c=0, pointers=0, aempty=1 and afull=0.
REQ-030 Reset SHALL take priority over flush, push and pop; reset mid-transfer SHALL discard all contents.
REQ-031 Storage array contents SHALL NOT require reset.

Structure
REQ-032 Package stdcore_pkg SHALL hold the count-width function (clog2 of DEPTH+1) and the pointer-wrap helper.
REQ-033 Storage SHALL be sub-module stdcore_rfifo_ram: (DEPTH-1) x DW, 1 write port, 1 asynchronous read port, no reset.
REQ-034 The top level SHALL contain the output register, pointers, count and flag decode.

Verification (DW=8, DEPTH=4, AF_LVL=3, AE_LVL=1)
REQ-035 Push 0x11 into empty FIFO with c_rdy=0 -> next cycle c_val=1, c=0x11, count=1, aempty=1.
REQ-036 Push 0x01..0x04 with c_rdy=0 -> count=4, p_rdy=0, afull=1 from count=3; then c_rdy=1 for 4 cycles -> c=0x01,0x02,0x03,0x04 in order, then c_val=0 with c holding 0x04.
REQ-037 Continuous p_val=1 and c_rdy=1 streaming 0x00..0x0F -> one word per cycle, count steady at 1, pointers wrap without gaps.
REQ-038 Random p_val and c_rdy (50%) for 2000 cycles against a scoreboard -> order exact, c stable while stalled, count equals scoreboard occupancy every cycle.
REQ-039 count=3, then flush=1 for one cycle with p_val=1 -> p_rdy=0 that cycle; next cycle count=0, c_val=0, c unchanged.
REQ-040 count=2, then rst_n=0 together with flush=1 for one cycle -> count=0, c=0x00, c_val=0, aempty=1; the next push is delivered with latency 1.

Source files
------------

// File: rtl/stdcore_pkg.sv
// Shared sizing and pointer helpers for the stdcore register-output FIFO family.
package stdcore_pkg;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // A one-entry buffer still needs a one-bit pointer.
   function automatic int ptr_w(input int depth);
      return (depth - 1 <= 1) ? 1 : $clog2(depth - 1);
   endfunction

   // Advances a circular-buffer pointer over depth-1 slots, wrapping after slot depth-2.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr >= depth - 2) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/stdcore_rfifo_ram.sv
// Circular-buffer storage behind the FIFO output register: one write port, async read, no reset.
module stdcore_rfifo_ram #(
   parameter int DW    = 1,
   parameter int DEPTH = 4,
   parameter int AW    = 1
)(
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:DEPTH-2];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/stdcore_rfifo_lvl.sv
// Val/rdy FIFO with a registered output stage, occupancy count and almost-full/empty flags.
module stdcore_rfifo_lvl
   import stdcore_pkg::*;
#(
   parameter int DW     = 1,
   parameter int DEPTH  = 4,
   parameter int AF_LVL = DEPTH - 1,
   parameter int AE_LVL = 1
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic [DW-1:0]             p,
   input  logic                      p_val,
   output logic                      p_rdy,
   output logic [DW-1:0]             c,
   output logic                      c_val,
   input  logic                      c_rdy,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      afull,
   output logic                      aempty
);

   localparam int CW = cnt_w(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   if (DEPTH < 2 || AF_LVL < 1 || AF_LVL > DEPTH || AE_LVL < 0 || AE_LVL > DEPTH - 1) begin : g_param_chk
      $error("stdcore_rfifo_lvl: illegal parameters DEPTH=%0d AF_LVL=%0d AE_LVL=%0d",
             DEPTH, AF_LVL, AE_LVL);
   end

   logic [PW-1:0] rptr, wptr;
   logic [DW-1:0] ram_rdata;
   logic          push, pop, buf_empty;
   logic          load_p, load_r, ram_we;

   assign p_rdy     = (count < DEPTH_C) & ~flush;
   assign push      = p_val & p_rdy;
   assign pop       = c_val & c_rdy;
   assign buf_empty = (count <= ONE_C);

   // Incoming word bypasses the buffer when the output register is (or is becoming) free
   // and nothing older is waiting behind it.
   assign load_p = push & (~c_val | (pop & buf_empty));
   assign load_r = pop & ~buf_empty;
   assign ram_we = push & ~load_p;

   stdcore_rfifo_ram #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wptr),
      .wdata (p),
      .raddr (rptr),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
         c_val <= 1'b0;
         c     <= '0;
         rptr  <= '0;
         wptr  <= '0;
      end else if (flush) begin
         count <= '0;
         c_val <= 1'b0;
         rptr  <= '0;
         wptr  <= '0;
      end else begin
         if (push && !pop)      count <= count + ONE_C;
         else if (pop && !push) count <= count - ONE_C;

         if (load_p) begin
            c     <= p;
            c_val <= 1'b1;
         end else if (load_r) begin
            c     <= ram_rdata;
            c_val <= 1'b1;
         end else if (pop) begin
            c_val <= 1'b0;
         end

         if (load_r) rptr <= PW'(ptr_inc(32'(rptr), DEPTH));
         if (ram_we) wptr <= PW'(ptr_inc(32'(wptr), DEPTH));
      end
   end

   assign afull  = (count >= AF_C);
   assign aempty = (count <= AE_C);

endmodule

// File: tb/tb_stdcore_rfifo_lvl.sv
// Scenario bench for stdcore_rfifo_lvl against a queue-based FIFO model.
module tb_stdcore_rfifo_lvl;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n, flush, p_val, p_rdy, c_val, c_rdy, afull, aempty;
   logic [7:0] p, c;
   logic [2:0] count;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] q[$];
   logic [7:0] last_c = 8'h00;
   bit         rdy_seen, m_rdy;

   stdcore_rfifo_lvl #(
      .DW     (8),
      .DEPTH  (DEPTH),
      .AF_LVL (3),
      .AE_LVL (1)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .p      (p),
      .p_val  (p_val),
      .p_rdy  (p_rdy),
      .c      (c),
      .c_val  (c_val),
      .c_rdy  (c_rdy),
      .count  (count),
      .afull  (afull),
      .aempty (aempty)
   );

   always #5 clk = ~clk;

   // Observable state packed as {c_val, c, count, afull, aempty}.
   function automatic logic [13:0] exp_vec();
      int n = q.size();
      return {n > 0, last_c, 3'(n), n >= 3, n <= 1};
   endfunction

   function automatic logic [13:0] dut_vec();
      return {c_val, c, count, afull, aempty};
   endfunction

   // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
   task automatic step(input bit rs, input bit pv, input logic [7:0] pd, input bit cr, input bit fl);
      bit do_pop, do_push;
      rst_n = rs; p_val = pv; p = pd; c_rdy = cr; flush = fl;
      #1;
      rdy_seen = p_rdy;
      m_rdy    = (q.size() < DEPTH) && !fl;
      do_pop   = cr && (q.size() > 0);
      do_push  = pv && m_rdy;
      @(posedge clk);
      if (!rs) begin
         q.delete();
         last_c = 8'h00;
      end else if (fl) begin
         q.delete();
      end else begin
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back(pd);
      end
      if (q.size() > 0) last_c = q[0];
      @(negedge clk);
   endtask

   task automatic test_reset();
      step(0, 0, 8'h00, 0, 0);
      step(0, 1, 8'hAA, 1, 1);
      n_chk++;
      if (dut_vec() !== {1'b0, 8'h00, 3'd0, 1'b0, 1'b1})
         $display("FAIL reset_state: got %h want %h", dut_vec(), {1'b0, 8'h00, 3'd0, 1'b0, 1'b1});
      else n_pass++;
   endtask

   task automatic test_single_push();
      step(1, 1, 8'h11, 0, 0);
      n_chk++;
      if (dut_vec() !== {1'b1, 8'h11, 3'd1, 1'b0, 1'b1})
         $display("FAIL single_push: got %h want %h", dut_vec(), {1'b1, 8'h11, 3'd1, 1'b0, 1'b1});
      else n_pass++;
      step(1, 0, 8'h00, 1, 0);
      n_chk++;
      if (dut_vec() !== exp_vec()) $display("FAIL single_drain: got %h want %h", dut_vec(), exp_vec());
      else n_pass++;
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 4; i++) begin
         step(1, 1, 8'(i), 0, 0);
         n_chk++;
         if (dut_vec() !== {1'b1, 8'h01, 3'(i), i >= 3, i <= 1})
            $display("FAIL fill_%0d: got %h want %h", i, dut_vec(), {1'b1, 8'h01, 3'(i), i >= 3, i <= 1});
         else n_pass++;
      end
      step(1, 1, 8'hEE, 0, 0);
      n_chk++;
      if (rdy_seen !== 1'b0 || count !== 3'd4)
         $display("FAIL full_block: rdy %b count %0d want rdy 0 count 4", rdy_seen, count);
      else n_pass++;
      for (int k = 1; k <= 4; k++) begin
         step(1, 0, 8'h00, 1, 0);
         n_chk++;
         if (k < 4 && dut_vec() !== {1'b1, 8'(k + 1), 3'(4 - k), (4 - k) >= 3, (4 - k) <= 1})
            $display("FAIL drain_%0d: got %h want c=%h", k, dut_vec(), 8'(k + 1));
         else if (k == 4 && dut_vec() !== {1'b0, 8'h04, 3'd0, 1'b0, 1'b1})
            $display("FAIL drain_empty: got %h want %h", dut_vec(), {1'b0, 8'h04, 3'd0, 1'b0, 1'b1});
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         step(1, 1, 8'(i), 1, 0);
         n_chk++;
         if (c_val !== 1'b1 || c !== 8'(i) || count !== 3'd1 || rdy_seen !== 1'b1)
            $display("FAIL stream_%0d: c_val %b c %h count %0d rdy %b want 1 %h 1 1",
                     i, c_val, c, count, rdy_seen, 8'(i));
         else n_pass++;
      end
      step(1, 0, 8'h00, 1, 0);
      n_chk++;
      if (dut_vec() !== exp_vec()) $display("FAIL stream_end: got %h want %h", dut_vec(), exp_vec());
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 2000; i++) begin
         step(1, $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1, 0);
         n_chk++;
         if (dut_vec() !== exp_vec() || rdy_seen !== m_rdy)
            $display("FAIL random_%0d: got %h rdy %b want %h rdy %b", i, dut_vec(), rdy_seen, exp_vec(), m_rdy);
         else n_pass++;
      end
      while (q.size() > 0) step(1, 0, 8'h00, 1, 0);
   endtask

   task automatic test_flush();
      step(1, 1, 8'hA1, 0, 0);
      step(1, 1, 8'hA2, 0, 0);
      step(1, 1, 8'hA3, 0, 0);
      n_chk++;
      if (count !== 3'd3) $display("FAIL flush_setup: count %0d want 3", count);
      else n_pass++;
      step(1, 1, 8'hBB, 0, 1);
      n_chk++;
      if (rdy_seen !== 1'b0) $display("FAIL flush_rdy: got %b want 0", rdy_seen);
      else n_pass++;
      n_chk++;
      if (dut_vec() !== {1'b0, 8'hA1, 3'd0, 1'b0, 1'b1})
         $display("FAIL flush_state: got %h want %h", dut_vec(), {1'b0, 8'hA1, 3'd0, 1'b0, 1'b1});
      else n_pass++;
      step(1, 1, 8'hC1, 0, 0);
      step(1, 1, 8'hC2, 0, 0);
      step(1, 0, 8'h00, 1, 1);
      n_chk++;
      if (dut_vec() !== {1'b0, 8'hC1, 3'd0, 1'b0, 1'b1})
         $display("FAIL flush_pop: got %h want %h", dut_vec(), {1'b0, 8'hC1, 3'd0, 1'b0, 1'b1});
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      step(1, 1, 8'h31, 0, 0);
      step(1, 1, 8'h32, 0, 0);
      step(0, 1, 8'h33, 1, 1);
      n_chk++;
      if (dut_vec() !== {1'b0, 8'h00, 3'd0, 1'b0, 1'b1})
         $display("FAIL reset_mid: got %h want %h", dut_vec(), {1'b0, 8'h00, 3'd0, 1'b0, 1'b1});
      else n_pass++;
      step(1, 1, 8'h5A, 0, 0);
      n_chk++;
      if (dut_vec() !== {1'b1, 8'h5A, 3'd1, 1'b0, 1'b1})
         $display("FAIL reset_then_push: got %h want %h", dut_vec(), {1'b1, 8'h5A, 3'd1, 1'b0, 1'b1});
      else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; p_val = 1'b0; p = 8'h00; c_rdy = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_push();
      test_fill_drain();
      test_back_to_back();
      test_random();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
